// File: rtl/sort_loader_if.sv
// Handshake and RAM-side bundle between the sort loader and its neighbours.
// master: the loader (drives RAM writes, start, status).
// slave:  upstream source / sort core side.
interface sort_loader_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic              start;
  logic              sort_done;
  logic              busy;
  logic [7:0]        batch_cnt;

  modport master (
    input  in_valid, in_data, sort_done,
    output in_ready, ram_we, ram_addr, ram_wdata, start, busy, batch_cnt
  );

  modport slave (
    output in_valid, in_data, sort_done,
    input  in_ready, ram_we, ram_addr, ram_wdata, start, busy, batch_cnt
  );
endinterface

// File: rtl/sort_loader.sv
// Sort loader: streams DEPTH words into the sort core's RAM, fires a
// one-cycle start, then waits for a fresh sort_done rising edge.
//
// state | meaning
// IDLE  | one dead cycle after reset, not ready
// LOAD  | accepting words, one RAM write per accept
// FLUSH | final write on the RAM port, start issued on exit
// WAIT  | core sorting; wait for sort_done rising edge
module sort_loader #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input logic           clk,
  input logic           rst,
  sort_loader_if.master bus
);

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, WAIT} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] wr_ptr;
  logic              done_q;
  logic              ram_we_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [DATA_W-1:0] ram_wdata_q;
  logic              start_q;
  logic              busy_q;
  logic [7:0]        batch_cnt_q;
  logic              in_ready_c;
  logic              accept;
  logic              last_word;
  logic              done_rise;

  assign accept    = in_ready_c && bus.in_valid;
  assign last_word = (wr_ptr == ADDR_W'(DEPTH - 1));
  // A level already high on WAIT entry has done_q set, so it never counts.
  assign done_rise = bus.sort_done && !done_q;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and ready decode
  always_comb begin
    state_nxt  = state;
    in_ready_c = 1'b0;
    case (state)
      IDLE:  state_nxt = LOAD;
      LOAD: begin
        in_ready_c = 1'b1;
        if (accept && last_word) state_nxt = FLUSH;
      end
      FLUSH: state_nxt = WAIT;
      WAIT:  if (done_rise) state_nxt = LOAD;
      default: state_nxt = IDLE;
    endcase
  end

  // Write pointer and registered RAM write port
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr      <= '0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
    end else begin
      ram_we_q <= accept;
      if (accept) begin
        ram_addr_q  <= wr_ptr;
        ram_wdata_q <= bus.in_data;
        wr_ptr      <= last_word ? '0 : wr_ptr + ADDR_W'(1);
      end
    end
  end

  // Start pulse, busy flag, batch counter and sort_done history
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_q     <= 1'b0;
      busy_q      <= 1'b0;
      batch_cnt_q <= '0;
      done_q      <= 1'b0;
    end else begin
      done_q  <= bus.sort_done;
      start_q <= (state == FLUSH);
      if (accept && wr_ptr == '0) busy_q <= 1'b1;
      if (state == WAIT && done_rise) begin
        busy_q      <= 1'b0;
        batch_cnt_q <= batch_cnt_q + 8'd1;
      end
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.ram_we    = ram_we_q;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_wdata = ram_wdata_q;
  assign bus.start     = start_q;
  assign bus.busy      = busy_q;
  assign bus.batch_cnt = batch_cnt_q;

endmodule

// File: tb/tb_sort_loader.sv
// Randomized bench for sort_loader against a batch-level reference model.
module tb_sort_loader;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  sort_loader_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus();

  sort_loader #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model
  int                m_open, m_arm, m_cd, m_wait, m_count;
  logic              m_prev;
  logic              e_we, e_start, e_busy;
  logic [ADDR_W-1:0] e_addr;
  logic [DATA_W-1:0] e_data;
  logic [7:0]        e_batch;
  logic              last_acc;
  logic [DATA_W-1:0] acc_q[$];
  logic [DATA_W-1:0] tb_ram[DEPTH];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_open = 0; m_arm = 1; m_cd = 0; m_wait = 0; m_count = 0; m_prev = 1'b0;
    e_we = 1'b0; e_start = 1'b0; e_busy = 1'b0;
    e_addr = '0; e_data = '0; e_batch = '0; last_acc = 1'b0;
    acc_q.delete();
  endtask

  task automatic model_step(input logic iv, input logic [DATA_W-1:0] id, input logic sd);
    logic acc, rise;
    acc     = iv && (m_open != 0);
    rise    = (m_wait != 0) && sd && !m_prev;
    e_start = (m_cd == 1);
    if (m_arm != 0) begin m_open = 1; m_arm = 0; end
    if (m_cd == 1) begin m_wait = 1; m_cd = 0; end
    if (rise) begin
      e_batch = e_batch + 8'd1;
      e_busy  = 1'b0;
      m_wait  = 0;
      m_open  = 1;
    end
    e_we = acc;
    if (acc) begin
      e_addr = ADDR_W'(m_count);
      e_data = id;
      acc_q.push_back(id);
      if (m_count == 0) e_busy = 1'b1;
      m_count++;
      if (m_count == DEPTH) begin
        m_count = 0;
        m_open  = 0;
        m_cd    = 1;
      end
    end
    m_prev   = sd;
    last_acc = acc;
  endtask

  task automatic check_outputs();
    check("ram_we",    bus.ram_we,    e_we);
    check("ram_addr",  bus.ram_addr,  e_addr);
    check("ram_wdata", bus.ram_wdata, e_data);
    check("start",     bus.start,     e_start);
    check("busy",      bus.busy,      e_busy);
    check("batch_cnt", bus.batch_cnt, e_batch);
  endtask

  // One clock: ready before the edge, registered outputs just after it.
  task automatic tick();
    check("in_ready", bus.in_ready, m_open);
    @(posedge clk);
    model_step(bus.in_valid, bus.in_data, bus.sort_done);
    #1;
    if (bus.ram_we) tb_ram[bus.ram_addr] = bus.ram_wdata;
    check_outputs();
    if (e_start) begin
      check("batch_len", acc_q.size(), DEPTH);
      for (int i = 0; i < acc_q.size() && i < DEPTH; i++)
        check("ram_image", tb_ram[i], acc_q[i]);
      acc_q.delete();
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    check("rst_in_ready", bus.in_ready, 1'b0);
    check_outputs();
    @(posedge clk);
    #1;
    check_outputs();
    rst = 1'b0;
  endtask

  // bubble: 0 none, 1 alternate cycles, 2 random
  task automatic run_batch(input logic [DATA_W-1:0] w[DEPTH], input int i0,
                           input int n_end, input int bubble);
    int i, cyc;
    i = i0;
    cyc = 0;
    while (i < n_end && cyc < 200) begin
      if (bubble == 0)      bus.in_valid = 1'b1;
      else if (bubble == 1) bus.in_valid = (cyc % 2 == 0);
      else                  bus.in_valid = ($urandom_range(0, 3) != 0);
      bus.in_data = bus.in_valid ? w[i] : DATA_W'($urandom);
      tick();
      if (last_acc) i++;
      cyc++;
    end
    if (i < n_end) check("accept_timeout", i, n_end);
    bus.in_valid = 1'b0;
  endtask

  task automatic finish_batch(input int stale, input int aa);
    bus.in_valid  = (aa != 0);
    bus.in_data   = 8'hAA;
    bus.sort_done = (stale != 0);
    repeat (stale != 0 ? 12 : 2 + $urandom_range(0, 3)) tick();
    bus.sort_done = 1'b0;
    repeat (2) tick();
    bus.sort_done = 1'b1;
    tick();
    bus.sort_done = 1'b0;
  endtask

  logic [DATA_W-1:0] w_a[DEPTH];
  logic [DATA_W-1:0] w_b[DEPTH];
  logic [DATA_W-1:0] w_r[DEPTH];

  initial begin
    w_a = '{8'd5, 8'd3, 8'd7, 8'd1, 8'd8, 8'd2, 8'd6, 8'd4};
    w_b = '{8'd9, 8'd0, 8'd255, 8'd17, 8'd3, 8'd3, 8'd128, 8'd64};
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.sort_done = 1'b0;
    for (int i = 0; i < DEPTH; i++) tb_ram[i] = '0;

    do_reset();

    // back-to-back batch, clean done
    run_batch(w_a, 0, DEPTH, 0);
    finish_batch(0, 0);
    // alternate bubbles, stale done held on WAIT entry
    run_batch(w_a, 0, DEPTH, 1);
    finish_batch(1, 0);
    // second pattern, in_valid held with 0xAA through WAIT
    run_batch(w_b, 0, DEPTH, 0);
    finish_batch(0, 1);
    tick();
    bus.in_valid = 1'b0;
    w_r = w_b;
    w_r[0] = 8'hAA;
    run_batch(w_r, 1, DEPTH, 2);
    finish_batch(0, 0);

    // abandon a batch after 4 accepts
    run_batch(w_b, 0, 4, 0);
    do_reset();
    run_batch(w_a, 0, DEPTH, 0);
    finish_batch(0, 0);

    // 255 more random batches: counter wraps back to 0
    repeat (255) begin
      for (int i = 0; i < DEPTH; i++) w_r[i] = DATA_W'($urandom);
      run_batch(w_r, 0, DEPTH, 2);
      finish_batch($urandom_range(0, 1), 0);
    end
    check("batch_wrap", bus.batch_cnt, 8'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
